// File: rtl/datapath_seq_if.sv
// datapath_seq_if: bundles the control/data bus of datapath_seq.
//   master: decode/memory side (drives start and operation fields, reads results)
//   slave : datapath_seq side
// Signals: start, alu_op, shift, rn, rm, rd, imm_b, cmp, wb_src, sximm5,
//          sximm8, mdata, PC (inputs to datapath); out, N, V, Z, busy, done
//          (outputs from datapath).
// Parameters must match those given to datapath_seq.
interface datapath_seq_if #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int PCW   = 8
);
  localparam int REGW = $clog2(NREGS);

  logic             start;
  logic [1:0]       alu_op;
  logic [1:0]       shift;
  logic [REGW-1:0]  rn;
  logic [REGW-1:0]  rm;
  logic [REGW-1:0]  rd;
  logic             imm_b;
  logic             cmp;
  logic [1:0]       wb_src;
  logic [WIDTH-1:0] sximm5;
  logic [WIDTH-1:0] sximm8;
  logic [WIDTH-1:0] mdata;
  logic [PCW-1:0]   PC;
  logic [WIDTH-1:0] out;
  logic             N;
  logic             V;
  logic             Z;
  logic             busy;
  logic             done;

  modport master (
    output start, alu_op, shift, rn, rm, rd, imm_b, cmp, wb_src,
           sximm5, sximm8, mdata, PC,
    input  out, N, V, Z, busy, done
  );

  modport slave (
    input  start, alu_op, shift, rn, rm, rd, imm_b, cmp, wb_src,
           sximm5, sximm8, mdata, PC,
    output out, N, V, Z, busy, done
  );
endinterface

// File: rtl/datapath_seq.sv
// datapath_seq: register file + A/B/C registers, 1-bit shifter, 2-op-bit ALU
// and NVZ status, driven by an internal micro-sequencer. One start pulse in
// IDLE latches the operation fields and runs LDB/LDA/EXE/WB as needed.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; aborts any operation, clears all state
//   bus    datapath_seq_if.slave (operation fields in; out/N/V/Z/busy/done out)
// Optional build macro DATAPATH_SEQ_DBG_EN adds:
//   dbg_rnum  in  register index
//   dbg_rdata out R[dbg_rnum], combinational, no side effects
module datapath_seq #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int PCW   = 8
) (
  input  logic          clk,
  input  logic          reset,
  datapath_seq_if.slave bus
`ifdef DATAPATH_SEQ_DBG_EN
  ,
  input  logic [$clog2(NREGS)-1:0] dbg_rnum,
  output logic [WIDTH-1:0]         dbg_rdata
`endif
);
  localparam int REGW = $clog2(NREGS);
  localparam int MSB  = WIDTH - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LDB, S_LDA, S_EXE, S_WB, S_DONE
  } state_t;

  state_t           state, nxt;
  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] a_q, b_q, c_q;
  logic             n_q, v_q, z_q, busy_q, done_q;

  // Operation fields captured at the accepting start edge
  logic [1:0]       op_q, shift_q, wbsrc_q;
  logic [REGW-1:0]  rn_q, rm_q, rd_q;
  logic             immb_q, cmp_q;
  logic [WIDTH-1:0] sximm5_q;

  logic [WIDTH-1:0] bsh, bop, res, wbdata;
  logic             ovf;

  always_comb begin
    unique case (shift_q)
      2'b01:   bsh = {b_q[MSB-1:0], 1'b0};
      2'b10:   bsh = {1'b0, b_q[MSB:1]};
      2'b11:   bsh = {b_q[MSB], b_q[MSB:1]};
      default: bsh = b_q;
    endcase
    bop = immb_q ? sximm5_q : bsh;
    ovf = 1'b0;
    unique case (op_q)
      2'b00: begin
        res = a_q + bop;
        ovf = (a_q[MSB] == bop[MSB]) && (res[MSB] != a_q[MSB]);
      end
      2'b01: begin
        res = a_q - bop;
        ovf = (a_q[MSB] != bop[MSB]) && (res[MSB] != a_q[MSB]);
      end
      2'b10:   res = a_q & bop;
      default: res = ~bop;
    endcase
  end

  // PC/sximm8/mdata are deliberately taken live in the WB cycle
  always_comb begin
    unique case (wbsrc_q)
      2'b01:   wbdata = WIDTH'(bus.PC);
      2'b10:   wbdata = bus.sximm8;
      2'b11:   wbdata = bus.mdata;
      default: wbdata = c_q;
    endcase
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:
        if (bus.start)
          nxt = (bus.wb_src != 2'b00) ? S_WB : (bus.imm_b ? S_LDA : S_LDB);
      S_LDB:   nxt = (op_q == 2'b11) ? S_EXE : S_LDA;
      S_LDA:   nxt = S_EXE;
      S_EXE:   nxt = cmp_q ? S_DONE : S_WB;
      S_WB:    nxt = S_DONE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
      z_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      op_q     <= '0;
      shift_q  <= '0;
      wbsrc_q  <= '0;
      rn_q     <= '0;
      rm_q     <= '0;
      rd_q     <= '0;
      immb_q   <= 1'b0;
      cmp_q    <= 1'b0;
      sximm5_q <= '0;
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      state  <= nxt;
      // Outputs registered from the next state so they align with the state
      busy_q <= (nxt != S_IDLE);
      done_q <= (nxt == S_DONE);
      unique case (state)
        S_IDLE:
          if (bus.start) begin
            op_q     <= bus.alu_op;
            shift_q  <= bus.shift;
            wbsrc_q  <= bus.wb_src;
            rn_q     <= bus.rn;
            rm_q     <= bus.rm;
            rd_q     <= bus.rd;
            immb_q   <= bus.imm_b;
            cmp_q    <= bus.cmp;
            sximm5_q <= bus.sximm5;
            // A reads as zero whenever LDA is skipped
            a_q      <= '0;
          end
        S_LDB: b_q <= regs[rm_q];
        S_LDA: a_q <= regs[rn_q];
        S_EXE:
          if (cmp_q) begin
            n_q <= res[MSB];
            v_q <= ovf;
            z_q <= (res == '0);
          end else begin
            c_q <= res;
          end
        S_WB:    regs[rd_q] <= wbdata;
        default: ;
      endcase
    end
  end

  assign bus.out  = c_q;
  assign bus.N    = n_q;
  assign bus.V    = v_q;
  assign bus.Z    = z_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

`ifdef DATAPATH_SEQ_DBG_EN
  assign dbg_rdata = regs[dbg_rnum];
`endif
endmodule
